// File: rtl/conv_mac_pkg.sv
//------------------------------------------------------------------------------
// Module  : conv_mac_pkg
// Purpose : Shared defaults and helper functions for the convolution
//           multiply-accumulate path: accumulator width calculation and the
//           saturating clamp applied to window results.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_mac_pkg;

  localparam int c_def_data_w = 8;
  localparam int c_def_ch     = 3;
  localparam int c_def_taps   = 9;
  localparam int c_def_out_w  = 16;

  // Wide signed carrier for clamping; comfortably exceeds any sane ACC_W.
  typedef logic signed [63:0] wide_t;

  // Accumulator width that can never overflow for CH channels over TAPS beats.
  function automatic int acc_width(input int data_w, input int ch, input int taps);
    return 2 * data_w + $clog2(ch) + $clog2(taps) + 1;
  endfunction

  // Clamp v into the OUT_W range of the selected number format.
  function automatic wide_t sat_clamp(input wide_t v, input bit is_signed, input int out_w);
    wide_t hi;
    wide_t lo;
    if (is_signed) begin
      hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (out_w - 1));
    end else begin
      hi = (wide_t'(1) <<< out_w) - wide_t'(1);
      lo = '0;
    end
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_accum_mac_lane.sv
//------------------------------------------------------------------------------
// Module  : mac_lane
// Purpose : One registered DATA_W x DATA_W multiplier, unsigned or signed.
// Ports   : clk, reset (async, active-high), en (load product),
//           a, b (operands), prod (registered 2*DATA_W product)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_lane
  import conv_mac_pkg::*;
#(
  parameter int DATA_W = c_def_data_w,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod
);

  logic [2*DATA_W-1:0] w_a;
  logic [2*DATA_W-1:0] w_b;

  // Extending both operands to the product width first makes the low
  // 2*DATA_W bits of a plain multiply correct for either number format.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a = {{DATA_W{a[DATA_W-1]}}, a};
      assign w_b = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin : g_unsigned
      assign w_a = {{DATA_W{1'b0}}, a};
      assign w_b = {{DATA_W{1'b0}}, b};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prod <= '0;
    else if (en)
      prod <= w_a * w_b;
  end

endmodule

`default_nettype wire

// File: rtl/conv_mac_accum.sv
//------------------------------------------------------------------------------
// Module  : conv_mac_accum
// Purpose : Multi-channel multiply-accumulate. Each beat carries CH
//           data/weight pairs; products are summed across channels and
//           accumulated over TAPS beats (or up to in_last), then saturated to
//           OUT_W and presented with a valid/ready handshake.
// Ports   : clk, reset (async, active-high)
//           in_valid/in_ready/in_last, data, weight  - beat input
//           out_valid/out_ready, result, sat_flag     - window result output
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_mac_accum
  import conv_mac_pkg::*;
#(
  parameter int DATA_W = c_def_data_w,
  parameter int CH     = c_def_ch,
  parameter int TAPS   = c_def_taps,
  parameter int SIGNED = 0,
  parameter int OUT_W  = c_def_out_w,
  parameter int ACC_W  = acc_width(DATA_W, CH, TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [CH*DATA_W-1:0]  data,
  input  logic [CH*DATA_W-1:0]  weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      result,
  output logic                  sat_flag
);

  localparam int                  c_cnt_w    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [c_cnt_w-1:0]  c_last_tap = c_cnt_w'(TAPS - 1);
  localparam bit                  c_signed   = (SIGNED != 0);

  logic                       r_run;
  logic                       r_s1_valid;
  logic                       r_s1_end;
  logic [c_cnt_w-1:0]         r_tap_cnt;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_out_valid;
  logic [OUT_W-1:0]           r_result;
  logic                       r_sat;

  logic                       w_stall;
  logic                       w_accept;
  logic                       w_in_end;
  logic [2*DATA_W-1:0]        w_prod     [CH];
  logic signed [ACC_W-1:0]    w_prod_ext [CH];
  logic signed [ACC_W-1:0]    w_chan_sum;
  logic signed [ACC_W-1:0]    w_acc_next;
  wide_t                      w_wide;
  wide_t                      w_clamped;
  logic                       w_sat;

  // Only a pending window end that cannot leave the output register blocks
  // the pipe; partial-window beats keep flowing behind a held result.
  assign w_stall  = r_out_valid & ~out_ready & r_s1_valid & r_s1_end;
  assign in_ready = r_run & ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_in_end = in_last | (r_tap_cnt == c_last_tap);

  generate
    for (genvar c = 0; c < CH; c++) begin : g_lane
      mac_lane #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .en    (w_accept),
        .a     (data[c*DATA_W +: DATA_W]),
        .b     (weight[c*DATA_W +: DATA_W]),
        .prod  (w_prod[c])
      );
      assign w_prod_ext[c] = {{(ACC_W-2*DATA_W){c_signed & w_prod[c][2*DATA_W-1]}}, w_prod[c]};
    end
  endgenerate

  always_comb begin
    w_chan_sum = '0;
    for (int c = 0; c < CH; c++)
      w_chan_sum = w_chan_sum + w_prod_ext[c];
  end

  assign w_acc_next = r_acc + w_chan_sum;
  assign w_wide     = {{(64-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
  assign w_clamped  = sat_clamp(w_wide, c_signed, OUT_W);
  // Any difference from the unclamped value means the clamp engaged.
  assign w_sat      = (w_clamped != w_wide);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_end    <= 1'b0;
      r_tap_cnt   <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;

      if (!w_stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_end  <= w_in_end;
          r_tap_cnt <= w_in_end ? '0 : r_tap_cnt + c_cnt_w'(1);
        end
        if (r_s1_valid) begin
          if (r_s1_end) begin
            // Final sum goes straight to the output; accumulator restarts so
            // the next window can follow without a bubble.
            r_acc       <= '0;
            r_result    <= w_clamped[OUT_W-1:0];
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
          end else begin
            r_acc <= w_acc_next;
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign sat_flag  = r_sat;

endmodule

`default_nettype wire
